// File: rtl/fsm_manual_mode_pkg.sv
// Shared definitions for the manual-mode traffic-light controller.
// Contents:
//   state_t : FSM state encoding (ALL_RED, GREEN, YELLOW, CLEAR)
//   clog2   : ceiling log2, used for lane-index and timer widths
//   max3    : maximum of three integers, used to size the phase timer
package fsm_manual_mode_pkg;

    typedef enum logic [1:0] {
        ST_ALL_RED = 2'd0,
        ST_GREEN   = 2'd1,
        ST_YELLOW  = 2'd2,
        ST_CLEAR   = 2'd3
    } state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return m;
    endfunction

endpackage

// File: rtl/fsm_manual_mode_multi_sw_sync.sv
// Multi-bit flop-chain synchroniser for the operator switches.
// Each bit is synchronised independently; a change on d_i appears on q_o
// after STAGES rising edges.
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-high reset, clears every stage
//   d_i  : raw asynchronous inputs
//   q_o  : synchronised outputs (last stage)
module sw_sync #(
    parameter int WIDTH  = 2,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] sync_q [STAGES];

    // Shift raw switches through the synchroniser chain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/fsm_manual_mode_multi.sv
// Manual-mode traffic-light controller for NUM_LANES lanes.
// One operator switch per lane; exactly one set (synchronised) switch
// requests green for that lane. Every handover runs green -> yellow ->
// all-red clearance with minimum-green and clearance timers.
// Ports:
//   clk            : system clock, rising edge
//   rst            : asynchronous active-high reset (lamps go all-red at once)
//   sw             : raw operator switches, asynchronous to clk
//   red_o          : per-lane red lamp (registered)
//   yellow_o       : per-lane yellow lamp (registered)
//   green_o        : per-lane green lamp (registered)
//   active_lane_o  : lane currently green/yellow (holds last lane otherwise)
//   active_valid_o : high in GREEN and YELLOW
//   conflict_o     : high while more than one synchronised switch is set
module fsm_manual_mode_multi
    import fsm_manual_mode_pkg::*;
#(
    parameter  int NUM_LANES        = 2,
    parameter  int MIN_GREEN_CYCLES = 4,
    parameter  int YELLOW_CYCLES    = 3,
    parameter  int ALLRED_CYCLES    = 2,
    parameter  int SYNC_STAGES      = 2,
    localparam int LANE_W           = (NUM_LANES > 1) ? clog2(NUM_LANES) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_LANES-1:0] sw,
    output logic [NUM_LANES-1:0] red_o,
    output logic [NUM_LANES-1:0] yellow_o,
    output logic [NUM_LANES-1:0] green_o,
    output logic [LANE_W-1:0]    active_lane_o,
    output logic                 active_valid_o,
    output logic                 conflict_o
);

    localparam int TW = clog2(max3(MIN_GREEN_CYCLES, YELLOW_CYCLES, ALLRED_CYCLES) + 1);

    logic [NUM_LANES-1:0] sw_s;
    logic                 seen_one_s;
    logic                 seen_multi_s;
    logic                 req_valid_s;
    logic [LANE_W-1:0]    req_idx_s;

    state_t               state_q, state_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [LANE_W-1:0]    lane_q, lane_d;
    logic [NUM_LANES-1:0] red_d, yellow_d, green_d;
    logic                 valid_d;

    sw_sync #(
        .WIDTH  (NUM_LANES),
        .STAGES (SYNC_STAGES)
    ) u_sw_sync (
        .clk (clk),
        .rst (rst),
        .d_i (sw),
        .q_o (sw_s)
    );

    // Request decode: a request exists only when exactly one switch is set
    always_comb begin
        seen_one_s   = 1'b0;
        seen_multi_s = 1'b0;
        req_idx_s    = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (sw_s[i]) begin
                if (seen_one_s) begin
                    seen_multi_s = 1'b1;
                end else begin
                    seen_one_s = 1'b1;
                    req_idx_s  = LANE_W'(i);
                end
            end else begin
                seen_multi_s = seen_multi_s;
            end
        end
        req_valid_s = seen_one_s & ~seen_multi_s;
    end

    // Next-state, phase timer and lane selection
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        lane_d  = lane_q;
        case (state_q)
            ST_ALL_RED: begin
                if (req_valid_s) begin
                    state_d = ST_GREEN;
                    lane_d  = req_idx_s;
                    timer_d = TW'(MIN_GREEN_CYCLES - 1);
                end else begin
                    state_d = ST_ALL_RED;
                end
            end
            ST_GREEN: begin
                // The request is re-evaluated every cycle, so a change made
                // during min-green takes effect as soon as the timer expires.
                if ((timer_q == '0) && (!req_valid_s || (req_idx_s != lane_q))) begin
                    state_d = ST_YELLOW;
                    timer_d = TW'(YELLOW_CYCLES - 1);
                end else if (timer_q != '0) begin
                    timer_d = timer_q - TW'(1);
                end else begin
                    timer_d = timer_q;
                end
            end
            ST_YELLOW: begin
                if (timer_q == '0) begin
                    state_d = ST_CLEAR;
                    timer_d = TW'(ALLRED_CYCLES - 1);
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            ST_CLEAR: begin
                if (timer_q == '0) begin
                    if (req_valid_s) begin
                        state_d = ST_GREEN;
                        lane_d  = req_idx_s;
                        timer_d = TW'(MIN_GREEN_CYCLES - 1);
                    end else begin
                        state_d = ST_ALL_RED;
                    end
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            default: begin
                state_d = ST_ALL_RED;
                timer_d = '0;
                lane_d  = '0;
            end
        endcase
    end

    // Lamp decode of the next state so lamps register together with the state
    always_comb begin
        red_d    = '1;
        yellow_d = '0;
        green_d  = '0;
        valid_d  = 1'b0;
        if (state_d == ST_GREEN) begin
            red_d[lane_d]   = 1'b0;
            green_d[lane_d] = 1'b1;
            valid_d         = 1'b1;
        end else if (state_d == ST_YELLOW) begin
            red_d[lane_d]    = 1'b0;
            yellow_d[lane_d] = 1'b1;
            valid_d          = 1'b1;
        end else begin
            valid_d = 1'b0;
        end
    end

    // FSM state, timer, lane and registered lamp/status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_ALL_RED;
            timer_q        <= '0;
            lane_q         <= '0;
            red_o          <= '1;
            yellow_o       <= '0;
            green_o        <= '0;
            active_valid_o <= 1'b0;
            conflict_o     <= 1'b0;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            lane_q         <= lane_d;
            red_o          <= red_d;
            yellow_o       <= yellow_d;
            green_o        <= green_d;
            active_valid_o <= valid_d;
            conflict_o     <= seen_multi_s;
        end
    end

    assign active_lane_o = lane_q;

endmodule

// File: tb/tb_fsm_manual_mode_multi.sv
module tb_fsm_manual_mode_multi;

    logic       clk;
    logic       rst;
    logic [3:0] sw;
    logic [3:0] red_o;
    logic [3:0] yellow_o;
    logic [3:0] green_o;
    logic [1:0] active_lane_o;
    logic       active_valid_o;
    logic       conflict_o;

    int n_checks;
    int n_fail;

    // {active_valid, red, yellow, green}
    localparam logic [12:0] P_R  = {1'b0, 4'b1111, 4'b0000, 4'b0000};
    localparam logic [12:0] P_G0 = {1'b1, 4'b1110, 4'b0000, 4'b0001};
    localparam logic [12:0] P_Y0 = {1'b1, 4'b1110, 4'b0001, 4'b0000};
    localparam logic [12:0] P_G1 = {1'b1, 4'b1101, 4'b0000, 4'b0010};
    localparam logic [12:0] P_G2 = {1'b1, 4'b1011, 4'b0000, 4'b0100};

    fsm_manual_mode_multi #(
        .NUM_LANES        (4),
        .MIN_GREEN_CYCLES (4),
        .YELLOW_CYCLES    (3),
        .ALLRED_CYCLES    (2),
        .SYNC_STAGES      (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .sw             (sw),
        .red_o          (red_o),
        .yellow_o       (yellow_o),
        .green_o        (green_o),
        .active_lane_o  (active_lane_o),
        .active_valid_o (active_valid_o),
        .conflict_o     (conflict_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [12:0] lamps();
        return {active_valid_o, red_o, yellow_o, green_o};
    endfunction

    // Stimulus only: reset pulse over two edges, released 1 time unit after an edge
    task automatic do_reset();
        rst = 1'b1;
        sw  = 4'b0000;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        sw  = 4'b0000;
        #3;
        n_checks++;
        if ({lamps(), active_lane_o, conflict_o} !== {P_R, 2'b00, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_async: got %b, expected %b", {lamps(), active_lane_o, conflict_o}, {P_R, 2'b00, 1'b0});
        end
        do_reset();
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if ({lamps(), conflict_o} !== {P_R, 1'b0}) begin
                n_fail++;
                $display("FAIL reset_hold cycle %0d: got %b, expected %b", k, {lamps(), conflict_o}, {P_R, 1'b0});
            end
        end
    endtask

    task automatic test_grant();
        logic [12:0] exp_tab [1:3];
        exp_tab[1] = P_R;
        exp_tab[2] = P_R;
        exp_tab[3] = P_G0;
        do_reset();
        sw = 4'b0001;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (lamps() !== exp_tab[k]) begin
                n_fail++;
                $display("FAIL grant cycle %0d: got %b, expected %b", k, lamps(), exp_tab[k]);
            end
        end
        n_checks++;
        if (active_lane_o !== 2'd0) begin
            n_fail++;
            $display("FAIL grant_lane: got %0d, expected 0", active_lane_o);
        end
    endtask

    task automatic test_handover();
        logic [12:0] exp_tab [1:9];
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (lamps() !== P_G0) begin
                n_fail++;
                $display("FAIL hold_green cycle %0d: got %b, expected %b", k, lamps(), P_G0);
            end
        end
        exp_tab[1] = P_G0; exp_tab[2] = P_G0;
        exp_tab[3] = P_Y0; exp_tab[4] = P_Y0; exp_tab[5] = P_Y0;
        exp_tab[6] = P_R;  exp_tab[7] = P_R;
        exp_tab[8] = P_G2; exp_tab[9] = P_G2;
        sw = 4'b0100;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (lamps() !== exp_tab[k]) begin
                n_fail++;
                $display("FAIL handover cycle %0d: got %b, expected %b", k, lamps(), exp_tab[k]);
            end
        end
        n_checks++;
        if (active_lane_o !== 2'd2) begin
            n_fail++;
            $display("FAIL handover_lane: got %0d, expected 2", active_lane_o);
        end
    endtask

    task automatic test_min_green();
        logic [12:0] exp_tab [1:12];
        exp_tab[1]  = P_R;  exp_tab[2]  = P_R;
        exp_tab[3]  = P_G0; exp_tab[4]  = P_G0; exp_tab[5] = P_G0; exp_tab[6] = P_G0;
        exp_tab[7]  = P_Y0; exp_tab[8]  = P_Y0; exp_tab[9] = P_Y0;
        exp_tab[10] = P_R;  exp_tab[11] = P_R;
        exp_tab[12] = P_G1;
        do_reset();
        sw = 4'b0001;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (lamps() !== exp_tab[k]) begin
                n_fail++;
                $display("FAIL min_green cycle %0d: got %b, expected %b", k, lamps(), exp_tab[k]);
            end
            if (k == 4) sw = 4'b0010;
        end
        n_checks++;
        if (active_lane_o !== 2'd1) begin
            n_fail++;
            $display("FAIL min_green_lane: got %0d, expected 1", active_lane_o);
        end
    endtask

    task automatic test_conflict();
        logic [12:0] exp_tab [1:13];
        logic        exp_cf;
        // Conflict from ALL_RED: lamps never leave all-red
        do_reset();
        sw = 4'b0011;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            #1;
            exp_cf = (k >= 3);
            n_checks++;
            if ({lamps(), conflict_o} !== {P_R, exp_cf}) begin
                n_fail++;
                $display("FAIL conflict_idle cycle %0d: got %b, expected %b", k, {lamps(), conflict_o}, {P_R, exp_cf});
            end
        end
        // Conflict during lane-0 green: treated as no request
        exp_tab[1]  = P_R;  exp_tab[2]  = P_R;
        exp_tab[3]  = P_G0; exp_tab[4]  = P_G0; exp_tab[5]  = P_G0; exp_tab[6] = P_G0;
        exp_tab[7]  = P_Y0; exp_tab[8]  = P_Y0; exp_tab[9]  = P_Y0;
        exp_tab[10] = P_R;  exp_tab[11] = P_R;  exp_tab[12] = P_R;  exp_tab[13] = P_R;
        do_reset();
        sw = 4'b0001;
        for (int k = 1; k <= 13; k++) begin
            @(posedge clk);
            #1;
            exp_cf = (k >= 7);
            n_checks++;
            if ({lamps(), conflict_o} !== {exp_tab[k], exp_cf}) begin
                n_fail++;
                $display("FAIL conflict_green cycle %0d: got %b, expected %b", k, {lamps(), conflict_o}, {exp_tab[k], exp_cf});
            end
            if (k == 4) sw = 4'b0011;
        end
    endtask

    task automatic test_async_reset();
        logic [12:0] exp_tab [1:8];
        exp_tab[1] = P_R;  exp_tab[2] = P_R;
        exp_tab[3] = P_G0; exp_tab[4] = P_G0; exp_tab[5] = P_G0; exp_tab[6] = P_G0;
        exp_tab[7] = P_Y0; exp_tab[8] = P_Y0;
        do_reset();
        sw = 4'b0001;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (lamps() !== exp_tab[k]) begin
                n_fail++;
                $display("FAIL pre_reset cycle %0d: got %b, expected %b", k, lamps(), exp_tab[k]);
            end
            if (k == 3) sw = 4'b0000;
        end
        // Second yellow cycle: reset mid-cycle, well before the next edge
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (lamps() !== P_R) begin
            n_fail++;
            $display("FAIL async_reset: got %b, expected %b", lamps(), P_R);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        sw  = 4'b0000;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if ({lamps(), conflict_o} !== {P_R, 1'b0}) begin
                n_fail++;
                $display("FAIL post_reset cycle %0d: got %b, expected %b", k, {lamps(), conflict_o}, {P_R, 1'b0});
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        sw       = 4'b0000;
        test_reset();
        test_grant();
        test_handover();
        test_min_green();
        test_conflict();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fsm_manual_mode_multi.md
Name: fsm_manual_mode_multi

Overview:
Parametrised manual-mode traffic-light controller for NUM_LANES lanes, each with one operator switch.
- Switches are synchronised; exactly one asserted switch requests green for that lane.
- Every handover goes through green -> yellow -> all-red clearance, with minimum green and clearance timers.
- Sits beside the automatic-mode FSM; its light vectors feed the lamp output mux.

Parameters:
NUM_LANES, 2, number of lanes/switches (>=2)
MIN_GREEN_CYCLES, 4, minimum cycles a granted green is held (>=1)
YELLOW_CYCLES, 3, cycles yellow is shown before clearance (>=1)
ALLRED_CYCLES, 2, all-red clearance cycles between any yellow and the next green (>=1)
SYNC_STAGES, 2, flop stages in the switch synchroniser (>=2)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
sw  input  NUM_LANES  raw operator switches, asynchronous to clk
red_o  output  NUM_LANES  per-lane red lamp
yellow_o  output  NUM_LANES  per-lane yellow lamp
green_o  output  NUM_LANES  per-lane green lamp
active_lane_o  output  LANE_W  index of the lane currently green/yellow; LANE_W = max(1, clog2(NUM_LANES))
active_valid_o  output  1  high in GREEN and YELLOW states
conflict_o  output  1  registered; high while synchronised sw has more than one bit set

Behaviour:
- Interface: single clock clk; rst is asynchronous, active-high.
- Reset (async, no clock needed): state=ALL_RED, timer=0, lane=0, synchroniser flops=0, conflict_o=0. Outputs: red_o all ones, yellow_o=0, green_o=0, active_lane_o=0, active_valid_o=0.
- Switch synchronisation: sw_s is SYNC_STAGES flops deep, so a sw change is visible in sw_s after SYNC_STAGES edges.
- Request decode: req_valid = popcount(sw_s)==1; req_idx = index of the set bit. Zero bits or more than one bit means no request.
- Lamp outputs: Moore decode of the registered state and lane, with no combinational path from sw.
  - The active lane shows exactly one of green or yellow.
  - All other lanes show red.
  - Every lane has exactly one lamp bit set in every cycle.
- FSM states: ALL_RED, GREEN, YELLOW, CLEAR.
  - ALL_RED: if req_valid, go to GREEN with lane<=req_idx and timer<=MIN_GREEN_CYCLES-1; otherwise stay.
  - GREEN: timer decrements to 0 and saturates.
    - If timer==0 and (!req_valid or req_idx!=lane), go to YELLOW with timer<=YELLOW_CYCLES-1.
    - Otherwise hold GREEN.
    - A changed request before min-green expiry is not lost; it is re-evaluated every cycle.
  - YELLOW: at timer==0 go to CLEAR with timer<=ALLRED_CYCLES-1; otherwise decrement. Requests are ignored, so yellow is never aborted or extended.
  - CLEAR: all lanes red.
    - At timer==0, if req_valid go straight to GREEN (same loading as ALL_RED); otherwise go to ALL_RED.
    - Otherwise decrement.
    - A request for the previous lane also completes the full clearance.
- Timing consequences:
  - Yellow lasts exactly YELLOW_CYCLES.
  - All-red between two greens lasts exactly ALLRED_CYCLES when a request is pending.
  - Green lasts at least MIN_GREEN_CYCLES.
- conflict_o is registered from sw_s. It is informational only and causes no state change beyond the "no request" semantics.
- Timer width: clog2(max(MIN_GREEN_CYCLES, YELLOW_CYCLES, ALLRED_CYCLES)+1).
- Illegal state encoding: next state is ALL_RED.
- rst asserted mid-operation in any state: lamps are forced to all-red immediately (asynchronously).

Decomposition:
- Package fsm_manual_mode_pkg holds:
  - state localparams ST_ALL_RED=2'd0, ST_GREEN=2'd1, ST_YELLOW=2'd2, ST_CLEAR=2'd3;
  - a clog2 helper function.
- Sub-module sw_sync (WIDTH, STAGES) holds the per-bit flop-chain synchroniser with async active-high reset to 0.

Test Plan:
All scenarios use NUM_LANES=4, MIN_GREEN=4, YELLOW=3, ALLRED=2, SYNC=2.
- Reset, sw=0 -> red_o=4'b1111, yellow_o=0, green_o=0, active_valid_o=0, conflict_o=0; holds for 20 cycles.
- Apply sw=4'b0001 at edge N -> green_o=4'b0001 and red_o=4'b1110 from edge N+3; active_lane_o=0, active_valid_o=1.
- Lane 0 green for 10 cycles, then sw=4'b0100:
  - yellow_o=4'b0001 for exactly 3 cycles;
  - red_o=4'b1111 for exactly 2 cycles;
  - then green_o=4'b0100, active_lane_o=2.
- sw=4'b0001, then 4'b0010 one edge after green appears -> green_o=4'b0001 for exactly 4 cycles, then yellow 3 cycles, clear 2 cycles, green_o=4'b0010.
- Conflict: from ALL_RED, sw=4'b0011 -> conflict_o=1 and lamps stay all-red. During lane-0 green, sw=4'b0011 -> after min green: yellow (3 cycles), clear (2 cycles), ALL_RED.
- Assert rst asynchronously in the 2nd yellow cycle -> red_o=4'b1111 and yellow_o=0 before the next clk edge. After release with sw=0, the block stays in ALL_RED.
